// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the level-tracking FIFO.
// Holds the level-width helper, default widths and the threshold legality check.
package fifo_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;

  // The level counter needs one extra bit to represent a completely full array.
  function automatic int unsigned lvl_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  function automatic bit thresholds_legal(input int unsigned addr_w, input int ae_lvl,
                                          input int af_lvl);
    return (ae_lvl >= 0) && (ae_lvl < af_lvl) && (af_lvl <= (2 ** addr_w));
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage array: synchronous write, asynchronous read, contents never reset.
module fifo_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_lvl.sv
// Synchronous first-word-fall-through FIFO with occupancy level and almost-full/empty flags.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags and clr_err.
module fifo_lvl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int          AF_LVL = 2 ** ADDR_W - 2,
  parameter int          AE_LVL = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int unsigned LW = lvl_w(ADDR_W);
  localparam logic [LW-1:0] Depth = LW'(2 ** ADDR_W);
  localparam logic [LW-1:0] AfL   = LW'(AF_LVL);
  localparam logic [LW-1:0] AeL   = LW'(AE_LVL);

  if (!thresholds_legal(ADDR_W, AE_LVL, AF_LVL)) begin : g_bad_thresholds
    $error("fifo_lvl: need 0 <= AE_LVL < AF_LVL <= 2**ADDR_W");
  end

  logic              wr_acc, rd_acc;
  logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ae_q, ae_d;
  logic              af_q, af_d;

  always_comb begin
    // A write into a full FIFO is fine when a read frees the head slot this cycle.
    wr_acc  = wr & (~full_q | rd);
    rd_acc  = rd & ~empty_q;
    w_ptr_d = wr_acc ? w_ptr_q + 1'b1 : w_ptr_q;
    r_ptr_d = rd_acc ? r_ptr_q + 1'b1 : r_ptr_q;
    level_d = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    empty_d = (level_d == '0);
    full_d  = (level_d == Depth);
    ae_d    = (level_d <= AeL);
    af_d    = (level_d >= AfL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= (AF_LVL == 0);
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (w_ptr_q),
    .wdata_i (w_data),
    .raddr_i (r_ptr_q),
    .rdata_o (r_data)
  );

  assign level        = level_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // A new error in the same cycle as clr_err wins, so nothing is silently lost.
  always_comb begin
    ovf_d = (ovf_q & ~clr_err) | (wr & ~wr_acc);
    unf_d = (unf_q & ~clr_err) | (rd & empty_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_lvl.sv
// Self-checking bench for fifo_lvl: vector table, directed corner sequences and random traffic
// against a queue-based reference model.
module tb_fifo_lvl;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif
  localparam int Depth = 16;
  localparam int AfLvl = 14;
  localparam int AeLvl = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
  logic [7:0] w_data = '0;
  logic [7:0] r_data;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] level;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mq[$];
  bit         m_ovf, m_unf;

  fifo_lvl #(
    .DATA_W (8),
    .ADDR_W (4),
    .AF_LVL (AfLvl),
    .AE_LVL (AeLvl)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr           (wr),
    .rd           (rd),
    .w_data       (w_data),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("level", 32'(level), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == Depth));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AeLvl));
    chk("almost_full", 32'(almost_full), 32'(n >= AfLvl));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    if (n > 0) chk("r_data", 32'(r_data), 32'(mq[0]));
  endtask

  // Apply one clock of stimulus, advance the model by the FIFO rules, compare after the edge.
  task automatic step(input bit w, input bit r, input logic [7:0] d, input bit c);
    int  n;
    bit  wacc, racc;
    n    = mq.size();
    wacc = w && (n < Depth || r);
    racc = r && (n > 0);
    if (racc) void'(mq.pop_front());
    if (wacc) mq.push_back(d);
    m_ovf = ErrEn && ((m_ovf && !c) || (w && !wacc));
    m_unf = ErrEn && ((m_unf && !c) || (r && n == 0));
    wr = w; rd = r; w_data = d; clr_err = c;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    check_model();
  endtask

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] wd;
    int         e_level;
    bit         e_empty;
    bit         e_full;
    bit         e_ae;
    bit         e_af;
    bit         e_chk_rd;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vecs[32];

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{wr: 1'b1, rd: 1'b0, wd: 8'(i), e_level: i + 1, e_empty: 1'b0,
                  e_full: (i + 1 == 16), e_ae: (i + 1 <= 2), e_af: (i + 1 >= 14),
                  e_chk_rd: 1'b1, e_rdata: 8'h00};
    end
    for (int k = 0; k < 16; k++) begin
      vecs[16 + k] = '{wr: 1'b0, rd: 1'b1, wd: 8'h00, e_level: 15 - k,
                       e_empty: (15 - k == 0), e_full: 1'b0, e_ae: (15 - k <= 2),
                       e_af: (15 - k >= 14), e_chk_rd: (15 - k > 0), e_rdata: 8'(k + 1)};
    end

    // Reset state, asserted asynchronously before any clock edge.
    #1 reset_n = 1'b0;
    #2;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Fill to full then drain, in order.
    for (int i = 0; i < 32; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].wd, 1'b0);
      chk("tbl_level", 32'(level), 32'(vecs[i].e_level));
      chk("tbl_empty", 32'(empty), 32'(vecs[i].e_empty));
      chk("tbl_full", 32'(full), 32'(vecs[i].e_full));
      chk("tbl_ae", 32'(almost_empty), 32'(vecs[i].e_ae));
      chk("tbl_af", 32'(almost_full), 32'(vecs[i].e_af));
      if (vecs[i].e_chk_rd) chk("tbl_rdata", 32'(r_data), 32'(vecs[i].e_rdata));
    end

    // Write while full without a read: dropped, overflow sets, clr_err clears it.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'(ErrEn));
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", 32'(r_data), 32'(8'h10 + i));
      step(1'b0, 1'b1, 8'h00, 1'b0);
    end

    // Read while empty.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("unf_level", 32'(level), 32'd0);
    chk("unf_empty", 32'(empty), 32'd1);
    chk("unf_flag", 32'(underflow), 32'(ErrEn));

    // Read+write while empty: write stored, read ignored.
    step(1'b1, 1'b1, 8'h55, 1'b0);
    chk("rw_empty_level", 32'(level), 32'd1);
    chk("rw_empty_rdata", 32'(r_data), 32'h55);
    chk("rw_empty_unf", 32'(underflow), 32'(ErrEn));

    // clr_err coinciding with a new underflow: set wins.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    chk("clr_vs_set", 32'(underflow), 32'(ErrEn));
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Read+write while full: both accepted, no overflow.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    step(1'b1, 1'b1, 8'hC3, 1'b0);
    chk("rw_full_level", 32'(level), 32'd16);
    chk("rw_full_full", 32'(full), 32'd1);
    chk("rw_full_ovf", 32'(overflow), 32'd0);
    chk("rw_full_head", 32'(r_data), 32'h21);
    while (mq.size() > 0) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Level 5 held through 40 simultaneous read/write cycles, wrapping both pointers.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      chk("pass_rdata", 32'(r_data), 32'(8'h40 + i));
      step(1'b1, 1'b1, 8'(8'h45 + i), 1'b0);
      chk("pass_level", 32'(level), 32'd5);
    end

    // Asynchronous reset mid-burst at level 9.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
    chk("pre_rst_level", 32'(level), 32'd9);
    wr = 1'b1; w_data = 8'hEE;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_unf", 32'(underflow), 32'd0);
    wr = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(1'b1, 1'b0, 8'h77, 1'b0);
    chk("post_rst_rdata", 32'(r_data), 32'h77);
    step(1'b1, 1'b1, 8'h88, 1'b0);
    chk("post_rst_pair", 32'(r_data), 32'h88);
    chk("post_rst_level", 32'(level), 32'd1);

    // Random traffic in phases biased toward filling, draining and balance.
    for (int i = 0; i < 3000; i++) begin
      int ph;
      bit w, r, c;
      ph = (i / 250) % 3;
      case (ph)
        0:       begin w = ($urandom_range(3) != 0); r = ($urandom_range(3) == 0); end
        1:       begin w = ($urandom_range(3) == 0); r = ($urandom_range(3) != 0); end
        default: begin w = $urandom_range(1) == 1;   r = $urandom_range(1) == 1;   end
      endcase
      c = ($urandom_range(15) == 0);
      step(w, r, 8'($urandom), c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
